// File: rtl/lutram_sdp.sv
// lutram_sdp: simple-dual-port distributed RAM with per-lane write enables,
// combinational or registered read, selectable read-during-write policy and
// an initialisation sequencer that fills every entry with INIT_VAL.
module lutram_sdp #(
    parameter int              DW       = 10,
    parameter int              AW       = 4,
    parameter int              LANE_W   = 10,
    parameter int              RD_REG   = 0,
    parameter int              WR_FIRST = 0,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 clr,
    input  logic                 we,
    input  logic [DW/LANE_W-1:0] wbe,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdat,
    input  logic [AW-1:0]        raddr,
    output logic [DW-1:0]        rdat,
    output logic                 ready
);

    localparam int NL    = DW / LANE_W;
    localparam int DEPTH = 1 << AW;

    if ((DW % LANE_W) != 0 || AW < 1) begin : g_bad_params
        $fatal(1, "lutram_sdp: DW must be a multiple of LANE_W and AW >= 1");
    end

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [AW-1:0]       ip;
    logic [DW-1:0]       mem [DEPTH];

    // Shared write port: the sequencer owns it in INIT, the user in RUN.
    logic [NL-1:0]       wr_lane;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_word;
    logic [DW-1:0]       rd_word;

    // Sequencer FSM: walk ip over every entry, then hand over to RUN.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_INIT;
            ip    <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (&ip) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                        ip    <= '0;
                    end else begin
                        ip <= ip + 1'b1;
                    end
                end
                S_RUN: begin
                    if (clr) begin
                        state <= S_INIT;
                        ready <= 1'b0;
                        ip    <= '0;
                    end
                end
                default: begin
                    state <= S_INIT;
                    ready <= 1'b0;
                    ip    <= '0;
                end
            endcase
        end
    end

    // Write-port mux: full-word init writes in INIT, lane-masked user writes in RUN.
    always_comb begin
        wr_lane = '0;
        wr_addr = waddr;
        wr_word = wdat;
        if (state == S_INIT) begin
            wr_lane = '1;
            wr_addr = ip;
            wr_word = INIT_VAL;
        end else if (we) begin
            wr_lane = wbe;
        end
    end

    // Array update; deliberately no reset so the tools can map it onto LUT RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (wr_lane[i]) begin
                mem[wr_addr][i*LANE_W +: LANE_W] <= wr_word[i*LANE_W +: LANE_W];
            end
        end
    end

    // Read word with optional write-first bypass of the lanes being written.
    always_comb begin
        rd_word = mem[raddr];
        if (WR_FIRST != 0 && ready && we && (raddr == waddr)) begin
            for (int i = 0; i < NL; i++) begin
                if (wbe[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = wdat[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [DW-1:0] rdat_p1;

        // Registered read: captures the (optionally merged) word each RUN edge.
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                rdat_p1 <= '0;
            end else begin
                rdat_p1 <= ready ? rd_word : '0;
            end
        end

        assign rdat = ready ? rdat_p1 : '0;
    end else begin : g_rd_comb
        assign rdat = ready ? rd_word : '0;
    end

endmodule

// File: doc/lutram_sdp.md
# lutram_sdp

Parametrised simple-dual-port distributed (LUT) RAM: one write port and one independent read port, with per-lane write enables, selectable combinational or registered read, selectable read-during-write policy, and a built-in initialisation sequencer that fills every entry with a known value after reset or on request. It is the general-purpose successor of the fixed 16x10 LUTRAM. It serves as the building block for the LUTRAM stress-test arrays and for small register files and FIFOs in GateMate designs.

## Interface
- DW, 10: data width in bits.
- AW, 4: address width; DEPTH = 2**AW entries.
- LANE_W, 10: write-lane width; DW must be an integer multiple of LANE_W; NL = DW/LANE_W lanes.
- RD_REG, 0: 0 = combinational read, 1 = registered read (1-cycle latency).
- WR_FIRST, 0: 1 = read of the address being written returns new data, 0 = returns old data.
- INIT_VAL, '0: DW-bit value written to every entry by the sequencer.

Ports:
- clk  in  1  clock, all state on rising edge.
- arst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  request re-initialisation, sampled only in RUN.
- we  in  1  write request.
- wbe  in  NL  lane enables; lane i covers wdat[i*LANE_W +: LANE_W].
- waddr  in  AW  write address.
- wdat  in  DW  write data.
- raddr  in  AW  read address.
- rdat  out  DW  read data.
- ready  out  1  1 = RUN state, writes accepted and rdat valid.

## Operation
- FSM states: INIT, RUN. arst_n low forces INIT with init pointer ip = 0, ready = 0.
- INIT: each rising edge writes INIT_VAL to mem[ip] and increments ip. The edge that writes ip = DEPTH-1 moves the FSM to RUN and clears ip to 0. User writes (we) are ignored in INIT. clr is ignored in INIT.
- RUN: on a rising edge with we = 1, each lane i with wbe[i] = 1 updates mem[waddr] lane i from wdat. Lanes with wbe[i] = 0 are unchanged. we = 1 with wbe = 0 is a no-op.
- RUN with clr = 1: the FSM goes to INIT on the next edge with ip = 0. A write presented in the same cycle as clr is performed.
- Memory array is not reset by arst_n; only the sequencer defines contents. No reset term on the array (LUTRAM inference).
- Read, RD_REG = 0: rdat = mem[raddr] combinationally. If WR_FIRST = 1, we = 1, ready = 1 and raddr == waddr, enabled lanes of rdat show wdat lanes and disabled lanes show stored data.
- Read, RD_REG = 1: rdat register loads mem[raddr] each edge in RUN. If WR_FIRST = 1, the same-address merge applies, so the register holds the post-write word. If WR_FIRST = 0, it holds the pre-write word.
- rdat is forced to 0 whenever ready = 0 (both modes; registered mode resets rdat to 0 and loads 0 while in INIT).
- Elaboration checks: DW % LANE_W == 0, AW >= 1; violation is a fatal elaboration error.

## Timing
- Reset values: ready = 0, rdat = 0, state = INIT, ip = 0.
- After arst_n rises, the first rising edge writes entry 0. ready rises after edge DEPTH (16 edges for defaults).
- clr sampled at edge N in RUN: ready = 0 after edge N, and ready = 1 again after edge N+DEPTH.
- Write latency: data is visible at the read port in the cycle after the write edge (RD_REG = 0), or after the second edge (RD_REG = 1, WR_FIRST = 0).
- Read latency: 0 cycles (RD_REG = 0) or 1 cycle (RD_REG = 1).
- arst_n asserted mid-INIT or mid-RUN: ready and rdat go to 0 immediately. INIT restarts from ip = 0 on release. Stale array contents are overwritten by the sequence.
- Simultaneous write and read of different addresses are fully independent.
- waddr/raddr wrap naturally within AW bits; no out-of-range case exists.

## Test plan
- Reset/init, defaults, INIT_VAL = 10'h155: release arst_n and count edges -> ready = 0 for 16 edges, then 1; reads of all 16 addresses -> 10'h155.
- Full write/readback, RD_REG = 0: write addr k with data k*10'h041 for k = 0..15, then read all -> exact values, rdat valid in the same cycle as raddr.
- Lane enables, DW = 16, LANE_W = 8: write 16'hAAAA with wbe = 2'b11, then 16'h1234 with wbe = 2'b01 -> read 16'hAA34.
- Read-during-write, RD_REG = 1, addr 3 holding 10'h00F, write 10'h3F0 and read addr 3 in the same cycle -> WR_FIRST = 1 gives rdat = 10'h3F0 next cycle; WR_FIRST = 0 gives 10'h00F.
- clr with simultaneous write in RUN: we = 1 to addr 5 with 10'h2AA and clr = 1 -> ready drops for 16 cycles. A write attempted during INIT is dropped. All entries including addr 5 read INIT_VAL afterwards.
- Reset mid-init: assert arst_n at INIT edge 7 -> rdat = 0 and ready = 0 asynchronously. After release, 16 full edges pass before ready = 1, and contents equal INIT_VAL.
